vdp_gfx_render: RTL
===================

VDP_GFX_RENDER -- requirements
Module: vdp_gfx_render

Interface
REQ-001 Parameter HSHIFT, default 0: right-shift applied to col_in to form the pixel x coordinate.
REQ-002 Parameter VSHIFT, default 2: right-shift applied to row_in to form the pixel y coordinate.
REQ-003 Parameter X0, default 0: pixel x of the field's left edge; Y0, default 0: pixel y of the field's top edge.
REQ-004 Parameter COL_W, default 11: col_in width; ROW_W, default 10: row_in width.
REQ-005 Port: pxclk, in, 1, sole clock; all state on the rising edge.
REQ-006 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-007 Ports: hsync_in, vsync_in, active_in, each in, 1: timing from vgasync, active-high.
REQ-008 Ports: col_in, in, COL_W; row_in, in, ROW_W: raster position.
REQ-009 Port: mode_in, in, 1: 0 = Graphics I, 1 = Graphics II.
REQ-010 Port: backdrop_in, in, 4: backdrop color index.
REQ-011 Port: blank_in, in, 1: 1 forces the field to backdrop.
REQ-012 Port: name_raddr, out, 10; name_rdata, in, 8: name table, 1-cycle synchronous read.
REQ-013 Port: pattern_raddr, out, 13; pattern_rdata, in, 8: pattern table, 1-cycle synchronous read.
REQ-014 Port: color_raddr, out, 13; color_rdata, in, 8: color table, 1-cycle synchronous read.
REQ-015 Ports: hsync_out, vsync_out, active_out, each out, 1; pix_color, out, 4: delayed timing and pixel color index.

Function
REQ-016 x = (col_in >> HSHIFT) - X0 and y = (row_in >> VSHIFT) - Y0, both 11-bit two's complement; in_field = active_in and 0 <= x <= 255 and 0 <= y <= 191.
REQ-017 Pipeline: edge t registers x, y, in_field and the timing bits; name_raddr = y[7:3]*32 + x[7:3] is driven from the stage-1 registers.
REQ-018 At edge t+2, name_rdata aligns with stage 2; pattern_raddr and color_raddr are driven from stage 2 and name_rdata.
REQ-019 Graphics I: pattern_raddr = {2'b00, name, y[2:0]}; color_raddr = {8'b0, name[7:3]}.
REQ-020 Graphics II: pattern_raddr = {y[7:6], name, y[2:0]}; color_raddr = {y[7:6], name, y[2:0]}.
REQ-021 At edge t+3 the data aligns with stage 3; bit = pattern_rdata[7 - x[2:0]], fg = color_rdata[7:4], bg = color_rdata[3:0].
REQ-022 At edge t+4 pix_color is registered as: not active -> 0; active and not in_field -> backdrop; in_field and blank -> backdrop; otherwise (bit ? fg : bg), with a result of 0 (transparent) replaced by backdrop.
REQ-023 hsync_out, vsync_out and active_out equal the corresponding inputs sampled at edge t, presented at edge t+4; fixed latency is 4 with no bubbles.
REQ-024 mode_in, backdrop_in and blank_in are latched into shadow registers only on the vsync_in 0->1 edge (previous-sample compare); mid-frame changes have no effect until the next frame.
REQ-025 Addresses change every pxclk; no handshake; the memories are read-only from this block and no write port exists.
REQ-026 Out-of-field cycles still drive in-range addresses (x, y masked to 8 bits) so that memory reads never exceed 767, 2047 (GI) or 6143 (GII).
REQ-027 Row 191 -> 192 transition: the first out-of-field pixel is backdrop; no table read from row 192 is displayed.

Reset
REQ-028 reset_n low asynchronously clears all pipeline stages, shadow registers (mode 0, backdrop 0, blank 0) and the vsync edge detector.
REQ-029 During reset and until 4 edges after release, the outputs are hsync_out = vsync_out = active_out = 0 and pix_color = 0.
REQ-030 A reset asserted mid-line or mid-frame takes effect immediately; after release, output resumes with the new inputs after 4 edges, with no stale pixels emitted.

Verification
REQ-031 GI, name[0] = 0x41, pattern[0x208] = 0x80, color[8] = 0xF4, col = 0, row = 0 (X0 = Y0 = 0) -> name_raddr = 0, pattern_raddr = 0x208, color_raddr = 8; pix_color = 0xF at edge +4, and x = 1 gives 0x4.
REQ-032 GII, row with y = 130 (third 2), name = 0x10, x = 3 -> pattern_raddr = color_raddr = {2'b10, 0x10, 3'd2} = 0x1082.
REQ-033 fg = 0 with bit = 1 and backdrop = 5 -> pix_color = 5; x = 256 -> 5; active_in = 0 -> 0.
REQ-034 Toggle mode_in and backdrop_in mid-frame -> output unchanged until after the next vsync_in rise, then the new mode and backdrop apply.
REQ-035 Pulse hsync_in for 34 cycles -> hsync_out reproduces the same 34-cycle pulse shifted by exactly 4 edges.
REQ-036 Assert reset_n low mid-line -> all outputs 0 asynchronously (before the next edge); after release, outputs are 0 for 4 edges, then resume with correct pixels.

Source files
------------

// File: rtl/vdp_gfx_render.sv
// rtl/vdp_gfx_render.sv - TMS9918-style Graphics I/II pattern renderer, fixed 4-edge pipeline
// Reads name, pattern and color tables in sequence; timing bits ride alongside the pixel.
module vdp_gfx_render #(
  parameter int HSHIFT = 0,
  parameter int VSHIFT = 2,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int COL_W  = 11,
  parameter int ROW_W  = 10
) (
  input  logic             pxclk,
  input  logic             reset_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             active_in,
  input  logic [COL_W-1:0] col_in,
  input  logic [ROW_W-1:0] row_in,
  input  logic             mode_in,
  input  logic [3:0]       backdrop_in,
  input  logic             blank_in,
  output logic [9:0]       name_raddr,
  input  logic [7:0]       name_rdata,
  output logic [12:0]      pattern_raddr,
  input  logic [7:0]       pattern_rdata,
  output logic [12:0]      color_raddr,
  input  logic [7:0]       color_rdata,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             active_out,
  output logic [3:0]       pix_color
);

  // timing bit order in every stage: {hsync, vsync, active}
  logic [10:0] x_full, y_full;
  logic        f1_d;
  logic [7:0]  x1_d, y1_d;
  logic [2:0]  t1_d;

  logic [7:0]  x1_q, y1_q;
  logic        f1_q;
  logic [2:0]  t1_q;
  logic [2:0]  x2_q;
  logic [7:0]  y2_q;
  logic        f2_q;
  logic [2:0]  t2_q;
  logic [2:0]  x3_q;
  logic        f3_q;
  logic [2:0]  t3_q;
  logic [3:0]  sel4_d, sel4_q;
  logic        f4_q;
  logic [2:0]  t4_q;
  logic [3:0]  pix_d, pix_q;
  logic [2:0]  tout_q;

  logic        vs_prev_q;
  logic        vs_rise;
  logic        mode_q, blank_q;
  logic [3:0]  bd_q;

  always_comb begin
    x_full = 11'(col_in >> HSHIFT) - 11'(X0);
    y_full = 11'(row_in >> VSHIFT) - 11'(Y0);
    f1_d   = active_in && (x_full[10:8] == 3'b000) && (y_full[10:8] == 3'b000)
             && (y_full[7:0] <= 8'd191);
    x1_d   = x_full[7:0];
    // Outside the field, y is folded below 64 so GII never addresses past the third bank.
    y1_d   = f1_d ? y_full[7:0] : {2'b00, y_full[5:0]};
    t1_d   = {hsync_in, vsync_in, active_in};
  end

  assign vs_rise = vsync_in & ~vs_prev_q;

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q <= 1'b0;
      mode_q    <= 1'b0;
      bd_q      <= 4'd0;
      blank_q   <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_rise) begin
        mode_q  <= mode_in;
        bd_q    <= backdrop_in;
        blank_q <= blank_in;
      end
    end
  end

  assign name_raddr = {y1_q[7:3], x1_q[7:3]};

  always_comb begin
    if (mode_q) begin
      pattern_raddr = {y2_q[7:6], name_rdata, y2_q[2:0]};
      color_raddr   = {y2_q[7:6], name_rdata, y2_q[2:0]};
    end else begin
      pattern_raddr = {2'b00, name_rdata, y2_q[2:0]};
      color_raddr   = {8'b0, name_rdata[7:3]};
    end
  end

  always_comb begin
    sel4_d = pattern_rdata[3'd7 - x3_q] ? color_rdata[7:4] : color_rdata[3:0];
    pix_d  = 4'd0;
    if (t4_q[0]) begin
      // Transparent (0) and blanked pixels both fall through to the backdrop.
      if (!f4_q || blank_q || (sel4_q == 4'd0)) pix_d = bd_q;
      else                                     pix_d = sel4_q;
    end
  end

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      x1_q   <= 8'd0;
      y1_q   <= 8'd0;
      f1_q   <= 1'b0;
      t1_q   <= 3'd0;
      x2_q   <= 3'd0;
      y2_q   <= 8'd0;
      f2_q   <= 1'b0;
      t2_q   <= 3'd0;
      x3_q   <= 3'd0;
      f3_q   <= 1'b0;
      t3_q   <= 3'd0;
      sel4_q <= 4'd0;
      f4_q   <= 1'b0;
      t4_q   <= 3'd0;
      pix_q  <= 4'd0;
      tout_q <= 3'd0;
    end else begin
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      f1_q   <= f1_d;
      t1_q   <= t1_d;
      x2_q   <= x1_q[2:0];
      y2_q   <= y1_q;
      f2_q   <= f1_q;
      t2_q   <= t1_q;
      x3_q   <= x2_q;
      f3_q   <= f2_q;
      t3_q   <= t2_q;
      sel4_q <= sel4_d;
      f4_q   <= f3_q;
      t4_q   <= t3_q;
      pix_q  <= pix_d;
      tout_q <= t4_q;
    end
  end

  assign hsync_out  = tout_q[2];
  assign vsync_out  = tout_q[1];
  assign active_out = tout_q[0];
  assign pix_color  = pix_q;

endmodule
